// File: rtl/riscV_unrn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscV_unrn_pkg
//  Description : Shared types and constants for the trap sequencer:
//                FSM state enum, exception cause codes, timer interrupt cause
//                and the trap-vector base helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscV_unrn_pkg;

  // Trap sequencer FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRAP_SAVE = 2'd1,
    TRAP_JUMP = 2'd2,
    MRET_JUMP = 2'd3
  } trap_state_t;

  // Synchronous exception codes (mcause values with interrupt bit clear)
  localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] EXC_INSTR_FAULT      = 4'd1;
  localparam logic [3:0] EXC_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] EXC_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] EXC_STORE_FAULT      = 4'd7;
  localparam logic [3:0] EXC_ECALL_M          = 4'd11;

  // Machine timer interrupt cause (interrupt bit set, code 7)
  localparam logic [31:0] MTIME_INT_CAUSE = 32'h8000_0007;

  // Word-aligned trap vector base; the two low mtvec bits carry the mode
  function automatic logic [31:0] trap_base(input logic [31:0] mtvec);
    return {mtvec[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : trap_sequencer
//  Description : Arbitrates synchronous exceptions, the machine timer
//                interrupt and MRET; sequences the CSR trap-save pulse and
//                the fetch redirect. Holds the pipeline while busy.
//                Optional feature macro: TRAP_VECTORED_EN (vectored
//                interrupt redirect when mtvec[0] is set).
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_sequencer
  import riscV_unrn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_boundary_i,
  input  logic [31:0] next_pc_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  output logic        exc_ack_o,
  input  logic        mret_i,
  input  logic [31:0] mepc_i,
  input  logic        mtime_exc_i,
  input  logic [31:0] mtvec_i,
  output logic        jumpingToMtvec_o,
  output logic [31:0] excCause_o,
  output logic [31:0] trapInfo_o,
  output logic [31:0] trap_pc_o,
  output logic        mret_done_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        stall_o
);

  trap_state_t state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] tval_q,  tval_d;
  logic [31:0] pc_q,    pc_d;

  logic [31:0] w_base;
  logic [31:0] w_trap_target;
  logic        w_unused_mtvec;

  assign w_base         = trap_base(mtvec_i);
  assign w_unused_mtvec = ^mtvec_i[1:0];

`ifdef TRAP_VECTORED_EN
  // Vectored mode only offsets interrupts; exceptions always land on the base
  assign w_trap_target = (mtvec_i[0] && cause_q[31])
                       ? (w_base + {26'd0, cause_q[3:0], 2'b00})
                       : w_base;
`else
  assign w_trap_target = w_base;
`endif

  // State and capture registers; reset clears everything asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= 32'd0;
      tval_q  <= 32'd0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state: fixed-priority arbitration in IDLE, fixed walk otherwise
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        if (exc_valid_i) begin
          state_d = TRAP_SAVE;
          cause_d = {28'd0, exc_code_i};
          tval_d  = exc_tval_i;
          pc_d    = exc_pc_i;
        end else if (mtime_exc_i && instr_boundary_i) begin
          state_d = TRAP_SAVE;
          cause_d = MTIME_INT_CAUSE;
          tval_d  = 32'd0;
          pc_d    = next_pc_i;
        end else if (mret_i) begin
          state_d = MRET_JUMP;
        end
      end
      TRAP_SAVE: state_d = TRAP_JUMP;
      TRAP_JUMP: state_d = IDLE;
      MRET_JUMP: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state; capture registers drive the CSR side
  always_comb begin
    // Ack is combinational on the request, so it is masked while reset is held
    exc_ack_o        = (state_q == IDLE) && exc_valid_i && !rst;
    jumpingToMtvec_o = 1'b0;
    mret_done_o      = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'd0;
    stall_o          = (state_q != IDLE);
    excCause_o       = cause_q;
    trapInfo_o       = tval_q;
    trap_pc_o        = pc_q;
    unique case (state_q)
      TRAP_SAVE: jumpingToMtvec_o = 1'b1;
      TRAP_JUMP: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = w_trap_target;
      end
      MRET_JUMP: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = mepc_i;
        mret_done_o      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have ports `clk` (in, 1, the single clock) and `rst` (in, 1); reset is asynchronous and active-high.
REQ-002 SHALL have `instr_boundary_i` (in, 1): core is between instructions; interrupts may be taken only when it is high.
REQ-003 SHALL have `next_pc_i` (in, 32): PC of the next instruction, used as saved PC for interrupts.
REQ-004 SHALL have `exc_valid_i` (in, 1), `exc_code_i` (in, 4), `exc_pc_i` (in, 32), `exc_tval_i` (in, 32): synchronous exception request.
REQ-005 SHALL have `exc_ack_o` (out, 1): one-cycle pulse when the exception request is captured.
REQ-006 SHALL have `mret_i` (in, 1): MRET executing; `mepc_i` (in, 32): current MEPC.
REQ-007 SHALL have `mtime_exc_i` (in, 1): timer interrupt pending and enabled, from the CSR unit.
REQ-008 SHALL have `mtvec_i` (in, 32): trap vector base; bit 0 is mode.
REQ-009 SHALL have `jumpingToMtvec_o` (out, 1), `excCause_o` (out, 32), `trapInfo_o` (out, 32), `trap_pc_o` (out, 32): drive the CSR unit trap-save inputs.
REQ-010 SHALL have `mret_done_o` (out, 1): pulse telling the CSR unit to restore `mstatus.mie`.
REQ-011 SHALL have `redirect_valid_o` (out, 1), `redirect_pc_o` (out, 32), and `stall_o` (out, 1): fetch redirect and pipeline hold.

Function
REQ-012 SHALL implement FSM states IDLE, TRAP_SAVE, TRAP_JUMP and MRET_JUMP.
REQ-013 In IDLE, arbitration SHALL use fixed priority: `exc_valid_i` > (`mtime_exc_i` && `instr_boundary_i`) > `mret_i`.
REQ-014 When an exception wins, the block SHALL pulse `exc_ack_o` in that cycle, register code/PC/tval, and enter TRAP_SAVE.
REQ-015 When the interrupt wins, the block SHALL register cause 0x8000_0007, tval 0 and `next_pc_i`, and enter TRAP_SAVE.
REQ-016 When `mret_i` wins, the block SHALL enter MRET_JUMP.
REQ-017 In TRAP_SAVE, `jumpingToMtvec_o` SHALL be 1 for exactly one cycle, with the registered cause (4-bit code zero-extended to 32), tval and PC; the FSM then moves to TRAP_JUMP.
REQ-018 In TRAP_JUMP, the block SHALL assert `redirect_valid_o` for one cycle with `redirect_pc_o` = {`mtvec_i`[31:2], 2'b00}, then return to IDLE.
REQ-019 In MRET_JUMP, the block SHALL assert `redirect_valid_o` and `mret_done_o` for one cycle with `redirect_pc_o` = `mepc_i`, then return to IDLE.
REQ-020 Latency SHALL be: request at cycle N gives trap save at N+1, redirect at N+2, and IDLE at N+3; MRET gives redirect at N+1.
REQ-021 `stall_o` SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-022 Requests arriving while not IDLE SHALL be neither acked nor lost; requesters hold `exc_valid_i` high until `exc_ack_o`.
REQ-023 A simultaneous exception and interrupt SHALL take the exception; the interrupt remains pending and is taken on a later IDLE boundary.
REQ-024 A simultaneous `mret_i` and exception SHALL take the exception, and no `mret_done_o` pulse SHALL occur.
REQ-025 Outputs `excCause_o`, `trapInfo_o` and `trap_pc_o` SHALL hold their last captured values outside TRAP_SAVE.

Reset
REQ-026 Asserting `rst` at any time, including mid-sequence, SHALL force IDLE and drive all outputs and capture registers to 0.
REQ-027 After release, the first request SHALL be accepted in the first cycle the block is in IDLE.

Configuration
REQ-028 With `TRAP_VECTORED_EN` defined and `mtvec_i`[0]=1, an interrupt redirect SHALL go to {`mtvec_i`[31:2], 2'b00} + 4*cause[3:0], i.e. base+0x1C for the timer; exceptions SHALL always use the base.
REQ-029 Without `TRAP_VECTORED_EN`, `mtvec_i`[1:0] SHALL be ignored and all traps SHALL redirect to the base.

Structure
REQ-030 The enum `trap_state_t`, the `EXC_*` exception codes and `MTIME_INT_CAUSE` (0x8000_0007) SHALL live in `riscV_unrn_pkg`.
REQ-031 The block SHALL be a single module with no sub-modules; arbitration and target-PC computation are inline.

Verification
REQ-032 Exception with code 2, PC 0x100, tval 0xDEAD -> ack at N; jumpingToMtvec=1, cause=2, trapInfo=0xDEAD, trap_pc=0x100 at N+1; redirect to 0x80 (mtvec 0x80) at N+2.
REQ-033 `mtime_exc_i`=1 with `instr_boundary_i` low -> no action; boundary then high with next_pc 0x204 -> cause 0x8000_0007, trap_pc 0x204.
REQ-034 Exception and timer interrupt in the same cycle -> exception trap first; timer trap follows once the FSM returns to IDLE.
REQ-035 `mret_i` with mepc 0x204 -> redirect 0x204 and mret_done=1 at N+1; stall high for 1 cycle.
REQ-036 `rst` pulsed during TRAP_SAVE -> all outputs 0 next cycle; a held exception is re-acked after release.
REQ-037 With `TRAP_VECTORED_EN` defined and mtvec 0x81 -> timer redirect 0x9C, exception redirect 0x80.
